seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is shown, legal range >= 1.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit when its bit is 0.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1; 1 = digit enabled when its anode bit is 0.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: 1 = scan and display; 0 = display dark, scan frozen.
REQ-008 SHALL have port load, input, 1 bit: capture value/dp_in into the shadow registers.
REQ-009 SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles; nibble i = value[4i+3:4i] for digit i, where digit 0 is least significant.
REQ-010 SHALL have port dp_in, input, NUM_DIGITS bits: decimal point request per digit.
REQ-011 SHALL have port lz_en, input, 1 bit: 1 = leading-zero suppression on.
REQ-012 SHALL have port seg, output, 7 bits, registered: seg[0]=a through seg[6]=g.
REQ-013 SHALL have port dp, output, 1 bit, registered: decimal point, same polarity as seg.
REQ-014 SHALL have port an, output, NUM_DIGITS bits, registered: one-hot digit enable, polarity per AN_ACTIVE_LOW.

Function
REQ-015 SHALL hold shadow_val (4*NUM_DIGITS) and shadow_dp (NUM_DIGITS); on a clk edge with load=1 they take value/dp_in, otherwise hold.
REQ-016 SHALL run a refresh counter 0..REFRESH_DIV-1 while en=1; at REFRESH_DIV-1 it wraps to 0 and digit index idx advances by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 SHALL freeze counter and idx while en=0; scanning resumes from the frozen values when en returns to 1.
REQ-018 SHALL, with REFRESH_DIV=1, advance idx every cycle; with NUM_DIGITS=1, hold idx at 0.
REQ-019 SHALL register seg/dp/an each cycle from the pre-edge idx, shadow_val and shadow_dp, giving 1-cycle latency from any of these to the outputs.
REQ-020 SHALL decode nibbles using the following active-low patterns (g..a), inverted when SEG_ACTIVE_LOW=0: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
REQ-021 SHALL, when lz_en=1, blank digit i>0 if nibble i and every nibble above it are 0; digit 0 SHALL never be suppressed.
REQ-022 SHALL, for a blanked digit, drive all segments off and dp per shadow_dp, while keeping the anode enabled.
REQ-023 SHALL, when en=0, drive seg off, dp off and all anodes disabled on the next edge.
REQ-024 SHALL, on simultaneous load and idx advance in the same cycle, apply both; the output for the new idx SHALL reflect the new shadow one edge later, per REQ-019.
REQ-025 SHALL enable exactly one anode at any time while en=1 and out of reset.

Reset
REQ-026 SHALL, while rst_n=0, force shadow_val=0, shadow_dp=0, counter=0 and idx=0 immediately, without waiting for clk.
REQ-027 SHALL, while rst_n=0, drive seg all-off, dp off and all anodes disabled.
REQ-028 SHALL, on the first edge after rst_n rises with en=1, show digit 0 as "0": seg=40h, an=1110b for defaults.
REQ-029 SHALL, on reset asserted mid-scan, abandon any partial refresh period and restart from idx 0.

Verification
REQ-030 Reset and idle: defaults, en=1, no load -> digit 0 shows 40h; an cycles 1110, 1101, 1011, 0111, one step every 50000 cycles.
REQ-031 Decode sweep: REFRESH_DIV=1, NUM_DIGITS=1, load each nibble 0..F -> seg matches the REQ-020 table 2 cycles after load.
REQ-032 Leading zeros: load value=0x0050, lz_en=1 -> digits 3 and 2 have segs off with anode on, digit 1=12h, digit 0=40h; with lz_en=0 -> digits 3 and 2 show 40h.
REQ-033 Enable gating: en dropped mid-period at idx=2 -> next edge seg=7Fh, an=1111b; en restored -> idx 2 resumes with its remaining count.
REQ-034 Collision: REFRESH_DIV=4, load=0xA5C3 on the idx-advance cycle -> new digit shows new nibble one edge later; no glitch and no two anodes enabled at once.
REQ-035 Async reset: rst_n pulsed low between clk edges mid-scan -> outputs go dark immediately; scan restarts at idx 0 showing 40h.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment display driver: shadows a hex value, scans one digit
// per refresh period and drives registered segment/decimal-point/anode outputs.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    logic [NUM_DIGITS-1:0][3:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]      r_shadow_dp;
    logic [CNT_W-1:0]           r_cnt;
    logic [IDX_W-1:0]           r_idx;
    logic [6:0]                 r_seg;
    logic                       r_dp;
    logic [NUM_DIGITS-1:0]      r_an;

    logic [NUM_DIGITS-1:0]      w_keep;
    logic                       w_acc;
    logic [6:0]                 w_pat;
    logic [NUM_DIGITS-1:0]      w_onehot;

    // Active-low g..a patterns.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;  4'h1: pat = 7'h79;  4'h2: pat = 7'h24;  4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;  4'h5: pat = 7'h12;  4'h6: pat = 7'h02;  4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;  4'h9: pat = 7'h10;  4'hA: pat = 7'h08;  4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;  4'hD: pat = 7'h21;  4'hE: pat = 7'h06;  default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
        end else if (load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (en) begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A digit is kept if it or any digit above it is non-zero; digit 0 always kept.
    always_comb begin
        w_acc  = 1'b0;
        w_keep = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc     = w_acc | (r_shadow_val[i] != 4'h0);
            w_keep[i] = w_acc | (i == 0) | ~lz_en;
        end
    end

    assign w_pat    = f_decode(r_shadow_val[r_idx]);
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
            r_an  <= AN_OFF;
        end else if (!en) begin
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
            r_an  <= AN_OFF;
        end else begin
            // Blanked digits keep their anode and decimal point.
            r_seg <= !w_keep[r_idx] ? SEG_OFF : (SEG_ACTIVE_LOW ? w_pat : ~w_pat);
            r_dp  <= r_shadow_dp[r_idx] ? ~DP_OFF : DP_OFF;
            r_an  <= AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: the stimulus process predicts each edge's outputs from a
// digit-level model; a negedge monitor pops and compares against the DUT.
module tb_seven_seg_scan_driver;
    localparam int N   = 4;
    localparam int DIV = 3;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [N-1:0]  dp_in = '0;
    logic          lz_en = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;

    int   ntot = 0;
    int   nbad = 0;
    int   cyc  = 0;
    exp_t q[$];
    exp_t e;

    // Reference model state: shadow contents and enabled-cycle count in the scan.
    logic [15:0]   m_val;
    logic [N-1:0]  m_dp;
    int            m_cnt;
    logic [6:0]    pat_tbl [16];

    seven_seg_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
        .dp_in(dp_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        ntot++;
        if (act != expv) begin
            nbad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) check("stale_entry", e.cyc, cyc);
            else begin
                check("seg", int'(seg), int'(e.seg));
                check("dp",  int'(dp),  int'(e.dp));
                check("an",  int'(an),  int'(e.an));
            end
        end
    end

    task automatic model_reset();
        m_val = '0;
        m_dp  = '0;
        m_cnt = 0;
    endtask

    // Predict the outputs of the coming edge, then advance the model across it.
    task automatic push_and_step();
        exp_t x;
        int   idx;
        logic [15:0] above;
        x.cyc = cyc + 1;
        if (!en) begin
            x.seg = 7'h7F; x.dp = 1'b1; x.an = 4'hF;
        end else begin
            idx   = m_cnt / DIV;
            above = m_val >> (4 * idx);
            x.seg = (lz_en && idx > 0 && above == 16'h0) ? 7'h7F : pat_tbl[above & 16'hF];
            x.dp  = ~m_dp[idx];
            x.an  = ~(4'b0001 << idx);
        end
        q.push_back(x);
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
        end
        if (en) m_cnt = (m_cnt + 1) % (N * DIV);
    endtask

    task automatic randomize_inputs();
        logic [15:0] mask;
        case ($urandom_range(0, 3))
            0: mask = 16'hFFFF;
            1: mask = 16'h00FF;
            2: mask = 16'h000F;
            default: mask = 16'h0000;
        endcase
        en    = ($urandom_range(0, 9) != 0);
        load  = ($urandom_range(0, 4) == 0);
        value = 16'($urandom) & mask;
        dp_in = N'($urandom);
        if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
    endtask

    // Asynchronous reset between edges: outputs must go dark before any clock.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("rst_seg", int'(seg), 'h7F);
        check("rst_dp",  int'(dp),  1);
        check("rst_an",  int'(an),  'hF);
        en = 1'b1; load = 1'b0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        pat_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_seg", int'(seg), 'h7F);
        check("reset_dp",  int'(dp),  1);
        check("reset_an",  int'(an),  'hF);
        #3;
        rst_n = 1'b1;
        en = 1'b1;
        push_and_step();
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk);
            #1;
            if (it == 700 || it == 1900) mid_reset();
            if (it < 24) begin
                en = 1'b1; load = 1'b0;
            end else if (it == 24) begin
                load = 1'b1; value = 16'h0050; dp_in = 4'b1000; lz_en = 1'b1;
            end else if (it < 40) begin
                load = 1'b0;
            end else if (it < 54) begin
                lz_en = 1'b0;
            end else if (it == 54) begin
                load = 1'b1; value = 16'hA5C3; dp_in = 4'b0101;
            end else begin
                randomize_inputs();
            end
            push_and_step();
        end
        @(posedge clk);
        #1;
        en = 1'b0; load = 1'b0;
        @(posedge clk);
        #6;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
